// File: rtl/score_event_gen.sv
// Score event generator: debounced hit/miss buttons become single-cycle score pulses.
// A lone hit scores +1 after a combo window, a second hit scores +2, a miss scores -2.
module score_event_gen #(
  parameter int unsigned COMBO_WINDOW = 16,
  parameter int unsigned LOCKOUT      = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic hitRaw,
  input  logic missRaw,
  output logic plus1,
  output logic plus2,
  output logic minus2,
  output logic comboActive
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam logic [7:0] WindowLoad  = 8'(COMBO_WINDOW - 1);
  localparam logic [7:0] LockoutLoad = 8'(LOCKOUT - 1);

  logic       hitS1, hitS2, hitPrev, hitArmed;
  logic       missS1, missS2, missPrev, missArmed;
  logic [1:0] syncVld;
  logic       hitEdge, missEdge;

  logic [1:0] state, stateD;
  logic [7:0] cnt, cntD;
  logic       plus1D, plus2D, minus2D, comboActiveD;

  // syncVld[1] marks s2 as holding a real sample rather than its reset value, so an
  // input held high through reset is not mistaken for having been seen low.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hitS1     <= 1'b0;
      hitS2     <= 1'b0;
      hitPrev   <= 1'b0;
      hitArmed  <= 1'b0;
      missS1    <= 1'b0;
      missS2    <= 1'b0;
      missPrev  <= 1'b0;
      missArmed <= 1'b0;
      syncVld   <= 2'b00;
    end else begin
      hitS1     <= hitRaw;
      hitS2     <= hitS1;
      hitPrev   <= hitS2;
      hitArmed  <= hitArmed | (syncVld[1] & ~hitS2);
      missS1    <= missRaw;
      missS2    <= missS1;
      missPrev  <= missS2;
      missArmed <= missArmed | (syncVld[1] & ~missS2);
      syncVld   <= {syncVld[0], 1'b1};
    end
  end

  assign hitEdge  = hitS2 & ~hitPrev & hitArmed;
  assign missEdge = missS2 & ~missPrev & missArmed;

  always_comb begin
    stateD  = state;
    cntD    = cnt;
    plus1D  = 1'b0;
    plus2D  = 1'b0;
    minus2D = 1'b0;
    case (state)
      IDLE: begin
        if (missEdge) begin
          minus2D = 1'b1;
          cntD    = LockoutLoad;
          stateD  = COOLDOWN;
        end else if (hitEdge) begin
          cntD   = WindowLoad;
          stateD = ARMED;
        end
      end
      ARMED: begin
        // Edges win over window expiry; a miss wins over a simultaneous hit.
        if (missEdge) begin
          minus2D = 1'b1;
          cntD    = LockoutLoad;
          stateD  = COOLDOWN;
        end else if (hitEdge) begin
          plus2D = 1'b1;
          cntD   = LockoutLoad;
          stateD = COOLDOWN;
        end else if (cnt == 8'd0) begin
          plus1D = 1'b1;
          stateD = IDLE;
        end else begin
          cntD = cnt - 8'd1;
        end
      end
      COOLDOWN: begin
        if (cnt == 8'd0) begin
          stateD = IDLE;
        end else begin
          cntD = cnt - 8'd1;
        end
      end
      default: begin
        stateD = IDLE;
        cntD   = 8'd0;
      end
    endcase
    comboActiveD = (stateD == ARMED);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      plus1       <= 1'b0;
      plus2       <= 1'b0;
      minus2      <= 1'b0;
      comboActive <= 1'b0;
    end else begin
      state       <= stateD;
      cnt         <= cntD;
      plus1       <= plus1D;
      plus2       <= plus2D;
      minus2      <= minus2D;
      comboActive <= comboActiveD;
    end
  end

endmodule

// File: doc/score_event_gen.md
SCORE_EVENT_GEN -- requirements
Module: score_event_gen

Interface
REQ-001 SHALL have parameter: COMBO_WINDOW, 16, number of cycles the block waits for a second hit after a first hit (legal range 2..255).
REQ-002 SHALL have parameter: LOCKOUT, 4, number of cooldown cycles after a plus2 or minus2 pulse (legal range 1..255).
REQ-003 SHALL have port: Clock  input  1  single clock for all state.
REQ-004 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: hitRaw  input  1  asynchronous target-hit button, active-high.
REQ-006 SHALL have port: missRaw  input  1  asynchronous miss/foul button, active-high.
REQ-007 SHALL have port: plus1  output  1  one-cycle pulse that adds 1 to the downstream score digit.
REQ-008 SHALL have port: plus2  output  1  one-cycle pulse that adds 2 to the downstream score digit.
REQ-009 SHALL have port: minus2  output  1  one-cycle pulse that subtracts 2 from the downstream score digit.
REQ-010 SHALL have port: comboActive  output  1  high while a first hit is pending (state ARMED).

Function
REQ-011 SHALL pass each raw input through its own 2-flop synchronizer (s1 then s2).
REQ-012 SHALL compute each input's edge as s2 & ~prev & armed: prev is s2 delayed by one cycle; armed is a per-input bit that is cleared by reset and set the first cycle s2==0.
REQ-013 SHALL make every output a register, updated on the same clock edge as the FSM transition that produces it.
REQ-014 SHALL have latency: raw input first sampled high at edge k -> pulse high for the cycle after edge k+2.
REQ-015 SHALL use FSM states IDLE, ARMED and COOLDOWN, plus an 8-bit down-counter cnt shared by ARMED and COOLDOWN.
REQ-016 SHALL, in IDLE on a miss edge, pulse minus2, load cnt=LOCKOUT-1 and go to COOLDOWN.
REQ-017 SHALL, in IDLE on a hit edge with no miss edge, load cnt=COMBO_WINDOW-1, go to ARMED and emit no pulse.
REQ-018 SHALL, in ARMED on a miss edge, discard the pending hit, pulse minus2, load cnt=LOCKOUT-1 and go to COOLDOWN.
REQ-019 SHALL, in ARMED on a hit edge with no miss edge, pulse plus2, load cnt=LOCKOUT-1 and go to COOLDOWN.
REQ-020 SHALL, in ARMED with no edge and cnt==0, pulse plus1 and go to IDLE.
REQ-021 SHALL, in ARMED with no edge and cnt!=0, decrement cnt.
REQ-022 SHALL let an edge arriving in the same cycle that cnt reaches 0 take priority over window expiry.
REQ-023 SHALL, in COOLDOWN, discard all edges (prev/armed still track), decrement cnt, and go to IDLE when cnt==0.
REQ-024 SHALL give a miss edge priority over a simultaneous hit edge; the hit is discarded.
REQ-025 SHALL keep plus1, plus2 and minus2 mutually exclusive, each high for exactly one cycle per event.
REQ-026 SHALL drive comboActive high exactly when state==ARMED (registered).

Reset
REQ-027 SHALL, on Reset high, immediately and asynchronously force state=IDLE, cnt=0, s1=s2=prev=0, armed=0, and plus1=plus2=minus2=comboActive=0.
REQ-028 SHALL, after reset deassertion, ignore an input held high until that input has been observed low at s2.
REQ-029 SHALL drop any pending hit when reset is asserted mid-ARMED, with no plus1 issued afterwards.

Verification
REQ-030 SHALL verify: hitRaw high 3 cycles then low -> comboActive high 16 cycles, then exactly one plus1 pulse; plus2 and minus2 stay 0.
REQ-031 SHALL verify: two hitRaw presses whose edges are 5 cycles apart -> one plus2 pulse, no plus1; a hit edge during the next 4 cycles gives no output.
REQ-032 SHALL verify: hit, then a miss edge 10 cycles later -> one minus2 pulse, no plus1; comboActive falls on the same edge.
REQ-033 SHALL verify: hitRaw and missRaw rise in the same cycle -> one minus2 pulse only, then COOLDOWN for 4 cycles; a hit edge at COOLDOWN cycle 2 is ignored.
REQ-034 SHALL verify: hitRaw held high across reset deassertion -> no pulse; after release and re-press -> normal ARMED entry.
REQ-035 SHALL verify: Reset pulsed at ARMED cycle 8 -> all outputs 0 without waiting for Clock, and no plus1 for 40 cycles after reset release.
